// File: rtl/push_counter_pkg.sv
// Shared types and constants for the multi-digit BCD push-button counter.
package push_counter_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [6:0] seg_pattern_t;

  localparam bcd_digit_t DIGIT_MAX = 4'd9;

  // Elaboration-time helper: turns an integer parameter (for example the
  // highest count) into packed BCD digits. Never used on live data.
  function automatic logic [15:0] const_to_bcd(input int unsigned value);
    int unsigned v;
    logic [15:0] r;
    v = value;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Active-low push button conditioner: 2-flop synchroniser, debouncer and a
// single-cycle press strobe on each accepted 1->0 transition.
// Optional feature macro: PUSH_COUNTER_AUTOREPEAT_EN adds REPEAT_DELAY /
// REPEAT_PERIOD auto-repeat strobes while the button stays accepted low.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
`ifdef PUSH_COUNTER_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY  = 5000000
  , parameter int REPEAT_PERIOD = 1000000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic press_strobe
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync_q;
  logic          accepted;
  logic [CW-1:0] stable_cnt;
  logic          differs;
  logic          expire;
  logic          accept_fall;
  logic          repeat_fire;

  // The level is taken over on the DEBOUNCE_CYCLES-th consecutive cycle of
  // disagreement; only a newly accepted low level counts as a press.
  always_comb begin
    differs     = (sync_q[1] != accepted);
    expire      = differs && (stable_cnt == CW'(DEBOUNCE_CYCLES - 1));
    accept_fall = expire && !sync_q[1];
  end

`ifdef PUSH_COUNTER_AUTOREPEAT_EN
  logic [31:0] rep_cnt;
  logic        rep_periodic;

  // Fires after REPEAT_DELAY held cycles, then every REPEAT_PERIOD cycles.
  always_comb begin
    repeat_fire = 1'b0;
    if (!accepted) begin
      if (rep_periodic) repeat_fire = (rep_cnt == 32'(REPEAT_PERIOD - 1));
      else              repeat_fire = (rep_cnt == 32'(REPEAT_DELAY - 1));
    end
  end

  // Hold-time counter, cleared whenever the button is accepted released.
  always_ff @(posedge clk) begin
    if (!reset || accepted) begin
      rep_cnt      <= '0;
      rep_periodic <= 1'b0;
    end else if (repeat_fire) begin
      rep_cnt      <= '0;
      rep_periodic <= 1'b1;
    end else begin
      rep_cnt      <= rep_cnt + 32'd1;
    end
  end
`else
  always_comb repeat_fire = 1'b0;
`endif

  // Synchroniser, debounce counter, accepted level and registered strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q       <= 2'b11;
      accepted     <= 1'b1;
      stable_cnt   <= '0;
      press_strobe <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], button};
      press_strobe <= accept_fall | repeat_fire;
      if (!differs) begin
        stable_cnt <= '0;
      end else if (expire) begin
        accepted   <= sync_q[1];
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_segment_display.sv
// One BCD digit to seven-segment pattern, active-high, bit order {g,f,e,d,c,b,a}.
// Codes 10..15 never occur on a valid digit and blank the display.
module seven_segment_display
  import push_counter_pkg::*;
(
  input  bcd_digit_t   digit,
  output seg_pattern_t segments
);

  // Pure lookup; segments follow the digit in the same cycle.
  always_comb begin
    segments = 7'h00;
    case (digit)
      4'd0: segments = 7'h3F;
      4'd1: segments = 7'h06;
      4'd2: segments = 7'h5B;
      4'd3: segments = 7'h4F;
      4'd4: segments = 7'h66;
      4'd5: segments = 7'h6D;
      4'd6: segments = 7'h7D;
      4'd7: segments = 7'h07;
      4'd8: segments = 7'h7F;
      4'd9: segments = 7'h6F;
      default: segments = 7'h00;
    endcase
  end

endmodule

// File: rtl/multi_digit_push_counter.sv
// Multi-digit BCD up/down counter driven by two active-low push buttons,
// with per-digit seven-segment outputs and a wrap/saturation pulse.
// Optional feature macro: PUSH_COUNTER_AUTOREPEAT_EN (held-button auto-repeat).
module multi_digit_push_counter
  import push_counter_pkg::*;
#(
  parameter int DIGITS          = 2,
  parameter int MAX_VALUE       = 99,
  parameter int WRAP            = 1,
  parameter int DEBOUNCE_CYCLES = 16
`ifdef PUSH_COUNTER_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY  = 5000000
  , parameter int REPEAT_PERIOD = 1000000
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                button_inc,
  input  logic                button_dec,
  output logic [4*DIGITS-1:0] count,
  output logic [7*DIGITS-1:0] hex_num,
  output logic                bound_pulse
);

  localparam logic [15:0]         MAX_BCD16 = const_to_bcd(MAX_VALUE);
  localparam logic [4*DIGITS-1:0] MAX_BCD   = MAX_BCD16[4*DIGITS-1:0];

  logic                inc_stb;
  logic                dec_stb;
  logic [4*DIGITS-1:0] count_next;
  logic                bound_next;
  logic                carry;

`ifdef PUSH_COUNTER_AUTOREPEAT_EN
  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_inc (.clk(clk), .reset(reset), .button(button_inc), .press_strobe(inc_stb));

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_dec (.clk(clk), .reset(reset), .button(button_dec), .press_strobe(dec_stb));
`else
  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_inc (.clk(clk), .reset(reset), .button(button_inc), .press_strobe(inc_stb));

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dec (.clk(clk), .reset(reset), .button(button_dec), .press_strobe(dec_stb));
`endif

  // Next count: bound handling at MAX/0, otherwise a decimal ripple of
  // carry (increment) or borrow (decrement) through the digits.
  always_comb begin
    count_next = count;
    bound_next = 1'b0;
    carry      = 1'b1;
    if (inc_stb && !dec_stb) begin
      if (count == MAX_BCD) begin
        bound_next = 1'b1;
        count_next = (WRAP != 0) ? '0 : MAX_BCD;
      end else begin
        for (int i = 0; i < DIGITS; i++) begin
          if (carry) begin
            if (count[4*i +: 4] == DIGIT_MAX) begin
              count_next[4*i +: 4] = 4'd0;
            end else begin
              count_next[4*i +: 4] = count[4*i +: 4] + 4'd1;
              carry = 1'b0;
            end
          end
        end
      end
    end else if (dec_stb && !inc_stb) begin
      if (count == '0) begin
        bound_next = 1'b1;
        count_next = (WRAP != 0) ? MAX_BCD : '0;
      end else begin
        for (int i = 0; i < DIGITS; i++) begin
          if (carry) begin
            if (count[4*i +: 4] == 4'd0) begin
              count_next[4*i +: 4] = DIGIT_MAX;
            end else begin
              count_next[4*i +: 4] = count[4*i +: 4] - 4'd1;
              carry = 1'b0;
            end
          end
        end
      end
    end
  end

  // Count and bound pulse registers; reset discards any strobe in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count       <= '0;
      bound_pulse <= 1'b0;
    end else begin
      count       <= count_next;
      bound_pulse <= bound_next;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    seven_segment_display u_seg (
      .digit   (count[4*g +: 4]),
      .segments(hex_num[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_multi_digit_push_counter.sv
// Bench for multi_digit_push_counter: a wrapping and a saturating instance
// share the buttons; each is checked against an arithmetic count model.
module tb_multi_digit_push_counter;

  localparam int DIGITS    = 2;
  localparam int MAX_VALUE = 99;
  localparam int DB        = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        button_inc = 1'b1;
  logic        button_dec = 1'b1;
  logic [7:0]  count_w, count_s;
  logic [13:0] hex_w, hex_s;
  logic        bound_w, bound_s;

  int n_checks = 0;
  int n_fail   = 0;
  int model_w  = 0;
  int model_s  = 0;
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

`ifdef PUSH_COUNTER_AUTOREPEAT_EN
  multi_digit_push_counter #(.DIGITS(DIGITS), .MAX_VALUE(MAX_VALUE), .WRAP(1),
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(20), .REPEAT_PERIOD(10)) dut_w (
    .clk(clk), .reset(reset), .button_inc(button_inc), .button_dec(button_dec),
    .count(count_w), .hex_num(hex_w), .bound_pulse(bound_w));
  multi_digit_push_counter #(.DIGITS(DIGITS), .MAX_VALUE(MAX_VALUE), .WRAP(0),
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(20), .REPEAT_PERIOD(10)) dut_s (
    .clk(clk), .reset(reset), .button_inc(button_inc), .button_dec(button_dec),
    .count(count_s), .hex_num(hex_s), .bound_pulse(bound_s));
`else
  multi_digit_push_counter #(.DIGITS(DIGITS), .MAX_VALUE(MAX_VALUE), .WRAP(1),
    .DEBOUNCE_CYCLES(DB)) dut_w (
    .clk(clk), .reset(reset), .button_inc(button_inc), .button_dec(button_dec),
    .count(count_w), .hex_num(hex_w), .bound_pulse(bound_w));
  multi_digit_push_counter #(.DIGITS(DIGITS), .MAX_VALUE(MAX_VALUE), .WRAP(0),
    .DEBOUNCE_CYCLES(DB)) dut_s (
    .clk(clk), .reset(reset), .button_inc(button_inc), .button_dec(button_dec),
    .count(count_s), .hex_num(hex_s), .bound_pulse(bound_s));
`endif

  // ---------------- reference model ----------------
  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [13:0] hex_of(input int v);
    return {seg_of(v / 10), seg_of(v % 10)};
  endfunction

  function automatic int step_model(input int v, input bit inc, input bit dec,
                                    input bit wrap, output bit bound);
    bound = 1'b0;
    if (inc && !dec) begin
      if (v == MAX_VALUE) begin bound = 1'b1; return wrap ? 0 : MAX_VALUE; end
      return v + 1;
    end
    if (dec && !inc) begin
      if (v == 0) begin bound = 1'b1; return wrap ? MAX_VALUE : 0; end
      return v - 1;
    end
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input bit exp_bw, input bit exp_bs);
    check_val({tag, "_count_w"}, 32'(count_w), 32'(to_bcd(model_w)));
    check_val({tag, "_count_s"}, 32'(count_s), 32'(to_bcd(model_s)));
    check_val({tag, "_hex_w"},   32'(hex_w),   32'(hex_of(model_w)));
    check_val({tag, "_hex_s"},   32'(hex_s),   32'(hex_of(model_s)));
    check_val({tag, "_bound_w"}, 32'(bound_w), 32'(exp_bw));
    check_val({tag, "_bound_s"}, 32'(bound_s), 32'(exp_bs));
  endtask

  task automatic apply_press(input bit inc, input bit dec, output bit bw, output bit bs);
    model_w = step_model(model_w, inc, dec, 1'b1, bw);
    model_s = step_model(model_s, inc, dec, 1'b0, bs);
    exp_q.push_back(to_bcd(model_w));
  endtask

  // ---------------- drivers ----------------
  // Clean press: buttons fall before edge 1, count must move at edge 7.
  task automatic press(input bit inc, input bit dec, input string tag);
    bit bw, bs;
    @(negedge clk);
    button_inc = ~inc;
    button_dec = ~dec;
    repeat (6) @(negedge clk);
    check_state({tag, "_early"}, 1'b0, 1'b0);
    apply_press(inc, dec, bw, bs);
    @(negedge clk);
    check_val({tag, "_sb_w"}, 32'(count_w), 32'(exp_q.pop_front()));
    check_state(tag, bw, bs);
    @(negedge clk);
    check_val({tag, "_pulse_end_w"}, 32'(bound_w), 32'd0);
    check_val({tag, "_pulse_end_s"}, 32'(bound_s), 32'd0);
    button_inc = 1'b1;
    button_dec = 1'b1;
    repeat (8) @(negedge clk);
    check_state({tag, "_release"}, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit bw, bs;
    int op;

    repeat (3) @(negedge clk);
    check_state("reset", 1'b0, 1'b0);
    reset = 1'b1;
    idle(2);

    press(1, 0, "first_inc");
    press(0, 1, "dec_to_zero");
    press(0, 1, "dec_at_zero");
    press(1, 0, "inc_at_max");

    // Full sweep: decimal carries, wrap at 99 and saturation at 99.
    for (int i = 0; i < 100; i++) press(1, 0, "sweep");
    press(1, 1, "cancel");

    // Bounce: low edges 1-3, high edge 4, low edges 5-9, then released.
    @(negedge clk);
    for (int e = 1; e <= 16; e++) begin
      button_inc = ((e >= 1 && e <= 3) || (e >= 5 && e <= 9)) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (e == 10) check_state("bounce_early", 1'b0, 1'b0);
      if (e == 11) begin
        apply_press(1, 0, bw, bs);
        check_val("bounce_sb_w", 32'(count_w), 32'(exp_q.pop_front()));
        check_state("bounce", bw, bs);
      end
      if (e == 16) check_state("bounce_once", 1'b0, 1'b0);
    end
    idle(6);
    check_state("bounce_release", 1'b0, 1'b0);

    // Randomised operations with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      idle($urandom_range(0, 5));
      op = $urandom_range(0, 2);
      case (op)
        0: press(1, 0, "rand_inc");
        1: press(0, 1, "rand_dec");
        default: press(1, 1, "rand_both");
      endcase
    end

    // Bring the wrapping counter to 42, then reset.
    for (int i = 0; i < 100 && model_w != 42; i++) press(1, 0, "to42");
    check_val("at42", 32'(count_w), 32'h42);
    @(negedge clk);
    reset = 1'b0;
    button_inc = 1'b0;
    @(negedge clk);
    model_w = 0;
    model_s = 0;
    check_state("reset42", 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Button held through reset release registers one press at edge 7.
    idle(6);
    check_state("held_early", 1'b0, 1'b0);
    apply_press(1, 0, bw, bs);
    @(negedge clk);
    check_val("held_sb_w", 32'(count_w), 32'(exp_q.pop_front()));
    check_state("held", bw, bs);
    idle(5);
    button_inc = 1'b1;
    idle(10);
    check_state("held_release", 1'b0, 1'b0);

    // Press whose strobe lands on a reset edge is dropped.
    @(negedge clk);
    button_inc = 1'b0;
    idle(5);
    button_inc = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_w = 0;
    model_s = 0;
    check_state("strobe_vs_reset", 1'b0, 1'b0);
    idle(12);
    check_state("strobe_vs_reset_after", 1'b0, 1'b0);

`ifdef PUSH_COUNTER_AUTOREPEAT_EN
    // Accepted low at edge 6; strobes at 6, 26, 36, 46, 56; released in time.
    @(negedge clk);
    button_inc = 1'b0;
    idle(57);
    button_inc = 1'b1;
    idle(15);
    for (int k = 0; k < 5; k++) begin
      apply_press(1, 0, bw, bs);
      void'(exp_q.pop_front());
    end
    check_state("autorepeat", 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
